// File: rtl/dpa_photo_seq.sv
// Photo-album header/descriptor sequencer: loads the album header from image memory, then offers
// each photo descriptor over valid/ready and holds it for DWELL cycles before moving on.
module dpa_photo_seq #(
  parameter int AW       = 20,
  parameter int DW       = 24,
  parameter int PCW      = 3,
  parameter int MAXPH    = 7,
  parameter int DWELL    = 1000000,
  parameter int HDR_BASE = 0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  output logic [AW-1:0]  IM_A,
  input  logic [DW-1:0]  IM_Q,
  output logic           cfg_valid,
  output logic [DW-1:0]  init_time,
  output logic [AW-1:0]  fb_addr,
  output logic [PCW-1:0] photo_cnt,
  output logic           desc_valid,
  input  logic           desc_ready,
  output logic [PCW-1:0] desc_idx,
  output logic [AW-1:0]  desc_addr,
  output logic [1:0]     desc_size,
  output logic           dwell_done,
  output logic           err
);

  localparam int            CW   = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [AW-1:0] BASE = AW'(HDR_BASE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DESC,
    S_OFFER,
    S_DWELL,
    S_ERR
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [1:0]     r_ph;
  logic [CW-1:0]  r_dcnt;

  logic [PCW-1:0] w_cnt_raw;
  logic [PCW-1:0] w_cnt_clamp;
  logic [PCW-1:0] w_idx_next;
  logic           w_hs;
  logic           w_dwell_last;

  // First IM word of descriptor idx; the size word follows it.
  function automatic logic [AW-1:0] desc_word0(input logic [PCW-1:0] idx);
    return BASE + AW'(3) + (AW'(idx) << 1);
  endfunction

  assign w_cnt_raw    = IM_Q[PCW-1:0];
  assign w_cnt_clamp  = (w_cnt_raw > PCW'(MAXPH)) ? PCW'(MAXPH) : w_cnt_raw;
  assign w_idx_next   = (desc_idx + PCW'(1) == photo_cnt) ? '0 : desc_idx + PCW'(1);
  assign w_hs         = (r_state == S_OFFER) && desc_valid && desc_ready;
  assign w_dwell_last = (r_dcnt == CW'(DWELL - 1));

  // NOTE: w_next is given its default before the case so every path assigns it and no latch forms.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_HDR;
      S_HDR:   if (r_ph == 2'd3) w_next = (w_cnt_raw == '0) ? S_ERR : S_DESC;
      S_DESC:  if (r_ph == 2'd2) w_next = S_OFFER;
      S_OFFER: if (w_hs) w_next = S_DWELL;
      S_DWELL: if (w_dwell_last) w_next = S_DESC;
      S_ERR:   w_next = S_ERR;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ph    <= '0;
    end else begin
      r_state <= w_next;
      r_ph    <= (w_next != r_state) ? 2'd0 : r_ph + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IM_A       <= BASE;
      cfg_valid  <= 1'b0;
      init_time  <= '0;
      fb_addr    <= '0;
      photo_cnt  <= '0;
      desc_valid <= 1'b0;
      desc_idx   <= '0;
      desc_addr  <= '0;
      desc_size  <= '0;
      dwell_done <= 1'b0;
      err        <= 1'b0;
      r_dcnt     <= '0;
    end else begin
      dwell_done <= 1'b0;
      case (r_state)
        S_HDR: begin
          // IM_Q lags IM_A by one cycle, so word k is captured in phase k+1.
          if (r_ph < 2'd2) IM_A <= IM_A + AW'(1);
          if (r_ph == 2'd1) init_time <= IM_Q;
          if (r_ph == 2'd2) fb_addr <= IM_Q[AW-1:0];
          if (r_ph == 2'd3) begin
            photo_cnt <= w_cnt_clamp;
            cfg_valid <= (w_cnt_raw != '0);
            err       <= (w_cnt_raw == '0);
            desc_idx  <= '0;
            IM_A      <= desc_word0('0);
          end
        end
        S_DESC: begin
          if (r_ph == 2'd0) IM_A <= IM_A + AW'(1);
          if (r_ph == 2'd1) desc_addr <= IM_Q[AW-1:0];
          if (r_ph == 2'd2) begin
            desc_size  <= IM_Q[8] ? 2'd0 : (IM_Q[7] ? 2'd1 : 2'd2);
            desc_valid <= 1'b1;
          end
        end
        S_OFFER: begin
          if (w_hs) begin
            desc_valid <= 1'b0;
            r_dcnt     <= '0;
          end
        end
        S_DWELL: begin
          r_dcnt     <= r_dcnt + CW'(1);
          dwell_done <= (r_dcnt == CW'(DWELL - 2));
          if (w_dwell_last) begin
            desc_idx <= w_idx_next;
            IM_A     <= desc_word0(w_idx_next);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dpa_photo_seq.sv
// Directed bench for dpa_photo_seq: header load, descriptor decode, backpressure, dwell timing,
// index wrap, mid-dwell reset, zero count and count clamping.
module tb_dpa_photo_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] IM_A;
  logic [23:0] IM_Q;
  logic        cfg_valid;
  logic [23:0] init_time;
  logic [19:0] fb_addr;
  logic [2:0]  photo_cnt;
  logic        desc_valid;
  logic        desc_ready;
  logic [2:0]  desc_idx;
  logic [19:0] desc_addr;
  logic [1:0]  desc_size;
  logic        dwell_done;
  logic        err;

  logic [23:0] mem [0:15];
  int total = 0;
  int bad   = 0;

  dpa_photo_seq #(
    .AW(20), .DW(24), .PCW(3), .MAXPH(4), .DWELL(16), .HDR_BASE(0)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .IM_A(IM_A), .IM_Q(IM_Q),
    .cfg_valid(cfg_valid), .init_time(init_time), .fb_addr(fb_addr), .photo_cnt(photo_cnt),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_idx(desc_idx),
    .desc_addr(desc_addr), .desc_size(desc_size), .dwell_done(dwell_done), .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous image memory: data appears the cycle after the address.
  always @(posedge clk) IM_Q <= mem[IM_A[3:0]];

  task automatic apply_reset();
    reset = 1'b0; start = 1'b0; desc_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_header_fetch(input string tag);
    for (int j = 0; j < 3; j++) begin
      total++;
      if (IM_A !== 20'(j)) begin
        bad++; $display("FAIL %s hdr_addr%0d got=%h want=%h", tag, j, IM_A, 20'(j));
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_cfg(input string tag);
    for (int t = 0; t < 10 && !cfg_valid && !err; t++) @(negedge clk);
    total++;
    if (cfg_valid !== 1'b1) begin
      bad++; $display("FAIL %s cfg_valid got=%b want=1", tag, cfg_valid);
    end
  endtask

  // Waits for an offer, checks it, optionally backpressures, then times the dwell.
  task automatic take_desc(input int idx, input logic [19:0] addr, input logic [1:0] sz,
                           input int hold, input bit early, input int nxt);
    logic [19:0] s_addr; logic [1:0] s_size; logic [2:0] s_idx;
    bit stable; int k;
    desc_ready = early;
    for (int t = 0; t < 100 && !desc_valid; t++) @(negedge clk);
    total++;
    if (desc_valid !== 1'b1) begin
      bad++; $display("FAIL offer%0d valid timeout got=%b want=1", idx, desc_valid);
      return;
    end
    total++;
    if ({desc_idx, desc_addr, desc_size} !== {3'(idx), addr, sz}) begin
      bad++;
      $display("FAIL offer%0d fields got idx=%0d addr=%h size=%0d want idx=%0d addr=%h size=%0d",
               idx, desc_idx, desc_addr, desc_size, idx, addr, sz);
    end
    if (hold > 0) begin
      s_addr = desc_addr; s_size = desc_size; s_idx = desc_idx; stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!desc_valid || desc_addr !== s_addr || desc_size !== s_size || desc_idx !== s_idx)
          stable = 1'b0;
      end
      total++;
      if (!stable) begin
        bad++; $display("FAIL offer%0d backpressure stable got=0 want=1", idx);
      end
    end
    desc_ready = 1'b1;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        desc_ready = 1'b0;
        total++;
        if (desc_valid !== 1'b0) begin
          bad++; $display("FAIL offer%0d valid_after_hs got=%b want=0", idx, desc_valid);
        end
      end
    end while (!dwell_done && k < 100);
    total++;
    if (k !== 16) begin
      bad++; $display("FAIL offer%0d dwell_cycles got=%0d want=16", idx, k);
    end
    @(negedge clk);
    total++;
    if (dwell_done !== 1'b0) begin
      bad++; $display("FAIL offer%0d dwell_pulse_width got=%b want=0", idx, dwell_done);
    end
    total++;
    if (IM_A !== 20'(3 + 2 * nxt)) begin
      bad++; $display("FAIL offer%0d next_addr got=%h want=%h", idx, IM_A, 20'(3 + 2 * nxt));
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; desc_ready = 1'b0;
    @(negedge clk);
    total++;
    if ({cfg_valid, desc_valid, dwell_done, err, init_time, fb_addr, photo_cnt,
         desc_idx, desc_addr, desc_size, IM_A} !== '0) begin
      bad++; $display("FAIL reset outputs got nonzero want all zero (IM_A=%h)", IM_A);
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({cfg_valid, desc_valid} !== 2'b00) begin
      bad++; $display("FAIL idle_no_start got=%b want=00", {cfg_valid, desc_valid});
    end
  endtask

  task automatic test_header();
    pulse_start();
    check_header_fetch("hdr");
    wait_cfg("hdr");
    total++;
    if ({init_time, fb_addr, photo_cnt, err} !== {24'h123456, 20'h0A000, 3'd3, 1'b0}) begin
      bad++;
      $display("FAIL hdr fields got init=%h fb=%h cnt=%0d err=%b want init=123456 fb=0a000 cnt=3 err=0",
               init_time, fb_addr, photo_cnt, err);
    end
  endtask

  task automatic test_descriptors();
    take_desc(0, 20'h01000, 2'd0, 50, 1'b0, 1);
    take_desc(1, 20'h02000, 2'd1, 0, 1'b1, 2);
    take_desc(2, 20'h03000, 2'd2, 0, 1'b0, 0);
    take_desc(0, 20'h01000, 2'd0, 0, 1'b1, 1);
  endtask

  task automatic test_reset_mid_dwell();
    for (int t = 0; t < 100 && !desc_valid; t++) @(negedge clk);
    desc_ready = 1'b1;
    repeat (6) @(negedge clk);
    desc_ready = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({cfg_valid, desc_valid, dwell_done, err, init_time, fb_addr, photo_cnt,
         desc_idx, desc_addr, desc_size, IM_A} !== '0) begin
      bad++; $display("FAIL mid_reset outputs got nonzero want all zero (IM_A=%h)", IM_A);
    end
    reset = 1'b1;
    @(negedge clk);
    pulse_start();
    check_header_fetch("rehdr");
    wait_cfg("rehdr");
    take_desc(0, 20'h01000, 2'd0, 0, 1'b1, 1);
  endtask

  task automatic test_count_zero();
    bit saw_valid = 1'b0;
    mem[2] = 24'h000008;
    apply_reset();
    pulse_start();
    repeat (40) begin
      @(negedge clk);
      if (desc_valid) saw_valid = 1'b1;
    end
    total++;
    if ({err, cfg_valid, saw_valid} !== 3'b100) begin
      bad++; $display("FAIL count_zero got err=%b cfg=%b valid_seen=%b want 1 0 0",
                      err, cfg_valid, saw_valid);
    end
  endtask

  task automatic test_clamp();
    mem[2]  = 24'h000007;
    mem[9]  = 24'h004000;
    mem[10] = 24'h000080;
    apply_reset();
    pulse_start();
    wait_cfg("clamp");
    total++;
    if (photo_cnt !== 3'd4) begin
      bad++; $display("FAIL clamp photo_cnt got=%0d want=4", photo_cnt);
    end
    take_desc(0, 20'h01000, 2'd0, 0, 1'b1, 1);
    take_desc(1, 20'h02000, 2'd1, 0, 1'b0, 2);
    take_desc(2, 20'h03000, 2'd2, 0, 1'b1, 3);
    take_desc(3, 20'h04000, 2'd1, 0, 1'b0, 0);
    take_desc(0, 20'h01000, 2'd0, 0, 1'b1, 1);
  endtask

  initial begin
    for (int j = 0; j < 16; j++) mem[j] = '0;
    mem[0] = 24'h123456; mem[1] = 24'h00A000; mem[2] = 24'h000003;
    mem[3] = 24'h001000; mem[4] = 24'h000100;
    mem[5] = 24'h002000; mem[6] = 24'h000080;
    mem[7] = 24'h003000; mem[8] = 24'h000000;
    test_reset();
    test_header();
    test_descriptors();
    test_reset_mid_dwell();
    test_count_zero();
    test_clamp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
